// File: rtl/relay_sequencer.sv
// relay_sequencer: orders the T/R relay and the PA enable around a transmit request
// so that the relay contacts never switch while RF is present.
// Latency: outputs are registered and change on the same edge as the state change.
// Backpressure: none; tx_req/inhibit are levels sampled on every clk edge.
//
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   tx_req          - clean transmit request level (already synchronous)
//   inhibit         - protection level; high forces a safe unkey and blocks keying
//   relay_tx        - T/R relay drive, 1 = transmit position
//   pa_enable       - PA bias/enable; tx_active mirrors it
//   rx_mute         - receiver mute, high while the relay is energised or settling
//   seq_state       - current state encoding for status readback
module relay_sequencer #(
  parameter int CNT_WIDTH     = 22,
  parameter int SETTLE_CYCLES = 1228800,
  parameter int HANG_CYCLES   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_req,
  input  logic       inhibit,
  output logic       relay_tx,
  output logic       pa_enable,
  output logic       tx_active,
  output logic       rx_mute,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    S_RX      = 3'd0,
    S_KEYING  = 3'd1,
    S_TX      = 3'd2,
    S_HANG    = 3'd3,
    S_UNKEY   = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  // Terminal counts; the counter starts at 0 on state entry, so N cycles end at N-1.
  localparam logic [CNT_WIDTH-1:0] SETTLE_TC = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HANG_TC   = CNT_WIDTH'(HANG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_nxt_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_relay;
  logic                 r_pa;
  logic                 r_mute;
  logic                 w_relay_nxt;
  logic                 w_pa_nxt;
  logic                 w_mute_nxt;
  logic                 w_settle_done;
  logic                 w_hang_done;
  logic                 w_key_ok;

  assign w_settle_done = (r_cnt == SETTLE_TC);
  assign w_hang_done   = (r_cnt == HANG_TC);
  // inhibit outranks tx_req everywhere, so keying is only ever allowed with it low.
  assign w_key_ok      = tx_req && !inhibit;

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_RX: begin
        if (w_key_ok) w_nxt_state = S_KEYING;
      end
      S_KEYING: begin
        // An aborted key still goes through a full release settle.
        if (!w_key_ok)          w_nxt_state = S_RELEASE;
        else if (w_settle_done) w_nxt_state = S_TX;
      end
      S_TX: begin
        if (inhibit)      w_nxt_state = S_UNKEY;
        else if (!tx_req) w_nxt_state = (HANG_CYCLES > 0) ? S_HANG : S_UNKEY;
      end
      S_HANG: begin
        if (inhibit)          w_nxt_state = S_UNKEY;
        else if (tx_req)      w_nxt_state = S_TX;
        else if (w_hang_done) w_nxt_state = S_UNKEY;
      end
      S_UNKEY, S_RELEASE: begin
        // Re-key beats terminal count: relay stays energised, settle restarts.
        if (w_key_ok)           w_nxt_state = S_KEYING;
        else if (w_settle_done) w_nxt_state = S_RX;
      end
      default: w_nxt_state = S_RX;
    endcase
  end

  // Counter clears on every state change and only runs in timed states, so it
  // never wraps while parked in RX or TX.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_nxt_state != r_state) begin
      w_cnt_nxt = '0;
    end else if (r_state inside {S_KEYING, S_HANG, S_UNKEY, S_RELEASE}) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    w_relay_nxt = 1'b0;
    w_pa_nxt    = 1'b0;
    w_mute_nxt  = 1'b0;
    case (w_nxt_state)
      S_KEYING, S_UNKEY, S_RELEASE: begin
        w_relay_nxt = 1'b1;
        w_mute_nxt  = 1'b1;
      end
      S_TX, S_HANG: begin
        w_relay_nxt = 1'b1;
        w_pa_nxt    = 1'b1;
        w_mute_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RX;
      r_cnt   <= '0;
      r_relay <= 1'b0;
      r_pa    <= 1'b0;
      r_mute  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_cnt_nxt;
      r_relay <= w_relay_nxt;
      r_pa    <= w_pa_nxt;
      r_mute  <= w_mute_nxt;
    end
  end

  assign relay_tx  = r_relay;
  assign pa_enable = r_pa;
  assign tx_active = r_pa;
  assign rx_mute   = r_mute;
  assign seq_state = r_state;

endmodule

// File: tb/tb_relay_sequencer.sv
// tb_relay_sequencer: table-driven bench with a scoreboard queue.
// Two instances share inputs: dut0 (HANG_CYCLES=0) and dut1 (HANG_CYCLES=5), SETTLE_CYCLES=8.
// Each step pushes the expected output word; the monitor pops it #1 after the edge.
module tb_relay_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_req = 1'b0;
  logic       inhibit = 1'b0;

  logic       d0_relay, d0_pa, d0_txa, d0_mute;
  logic [2:0] d0_st;
  logic       d1_relay, d1_pa, d1_txa, d1_mute;
  logic [2:0] d1_st;

  always #5 clk = ~clk;

  relay_sequencer #(.CNT_WIDTH(22), .SETTLE_CYCLES(8), .HANG_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .tx_req(tx_req), .inhibit(inhibit),
    .relay_tx(d0_relay), .pa_enable(d0_pa), .tx_active(d0_txa),
    .rx_mute(d0_mute), .seq_state(d0_st)
  );

  relay_sequencer #(.CNT_WIDTH(22), .SETTLE_CYCLES(8), .HANG_CYCLES(5)) dut1 (
    .clk(clk), .reset(reset), .tx_req(tx_req), .inhibit(inhibit),
    .relay_tx(d1_relay), .pa_enable(d1_pa), .tx_active(d1_txa),
    .rx_mute(d1_mute), .seq_state(d1_st)
  );

  typedef struct {
    int       n;
    bit       rst;
    bit       req;
    bit       inh;
    bit       sel;
    bit [2:0] st;
    int       tag;
  } vec_t;

  typedef struct {
    bit       sel;
    bit [5:0] exp;
    int       tag;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Output word {seq_state, relay_tx, pa_enable, tx_active, rx_mute} for each state.
  function automatic bit [5:0] expv(bit [2:0] st);
    case (st)
      3'd0:                 return {st, 4'b0000};
      3'd1, 3'd4, 3'd5:     return {st, 4'b1001};
      3'd2, 3'd3:           return {st, 4'b1111};
      default:              return 6'b111111;
    endcase
  endfunction

  function automatic void add(int n, bit rst, bit req, bit inh, bit sel, bit [2:0] st, int tag);
    vec_t v;
    v.n = n; v.rst = rst; v.req = req; v.inh = inh; v.sel = sel; v.st = st; v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic step(bit rst, bit req, bit inh, bit sel, bit [2:0] st, int tag);
    sb_t s;
    @(negedge clk);
    reset   = rst;
    tx_req  = req;
    inhibit = inh;
    s.sel = sel; s.exp = expv(st); s.tag = tag;
    sbq.push_back(s);
  endtask

  // Monitor: compares after each edge, plus the pa_enable => relay_tx invariant.
  always @(posedge clk) begin
    sb_t      e;
    bit [5:0] act;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      act = e.sel ? {d1_st, d1_relay, d1_pa, d1_txa, d1_mute}
                  : {d0_st, d0_relay, d0_pa, d0_txa, d0_mute};
      n_checks++;
      if (act === e.exp) n_pass++;
      else $display("FAIL test%0d dut%0d {st,relay,pa,txa,mute}: got %b want %b",
                    e.tag, e.sel, act, e.exp);
      n_checks++;
      if ((d0_pa !== 1'b1 || d0_relay === 1'b1) && (d1_pa !== 1'b1 || d1_relay === 1'b1))
        n_pass++;
      else $display("FAIL invariant pa_without_relay: got d0 %b%b d1 %b%b want relay=1 when pa=1",
                    d0_pa, d0_relay, d1_pa, d1_relay);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: basic key/unkey, no hang
    add(2,1,0,0,0,0,1); add(8,0,1,0,0,1,1); add(3,0,1,0,0,2,1);
    add(8,0,0,0,0,4,1); add(2,0,0,0,0,0,1);
    // 2: hang cancel then hang expiry (dut1)
    add(1,1,0,0,1,0,2); add(8,0,1,0,1,1,2); add(2,0,1,0,1,2,2);
    add(3,0,0,0,1,3,2); add(2,0,1,0,1,2,2); add(5,0,0,0,1,3,2);
    add(8,0,0,0,1,4,2); add(2,0,0,0,1,0,2);
    // 7: inhibit during hang goes straight to unkey (dut1)
    add(1,1,0,0,1,0,7); add(8,0,1,0,1,1,7); add(1,0,1,0,1,2,7);
    add(2,0,0,0,1,3,7); add(8,0,0,1,1,4,7); add(1,0,0,0,1,0,7);
    // 3: short pulse aborts keying into release
    add(1,1,0,0,0,0,3); add(3,0,1,0,0,1,3); add(8,0,0,0,0,5,3); add(2,0,0,0,0,0,3);
    // 8: inhibit in keying -> release; inhibit blocks keying from RX
    add(2,0,1,0,0,1,8); add(8,0,1,1,0,5,8); add(2,0,1,1,0,0,8); add(1,0,0,0,0,0,8);
    // 4: inhibit in TX skips the hang (dut1); re-key only after inhibit clears
    add(1,1,0,0,1,0,4); add(8,0,1,0,1,1,4); add(2,0,1,0,1,2,4);
    add(8,0,1,1,1,4,4); add(3,0,1,1,1,0,4); add(8,0,1,0,1,1,4); add(1,0,1,0,1,2,4);
    // 5: re-key at cycle 4 of unkey, then re-key exactly at unkey terminal count
    add(1,1,0,0,0,0,5); add(8,0,1,0,0,1,5); add(1,0,1,0,0,2,5);
    add(4,0,0,0,0,4,5); add(8,0,1,0,0,1,5); add(2,0,1,0,0,2,5);
    add(8,0,0,0,0,4,5); add(8,0,1,0,0,1,5); add(1,0,1,0,0,2,5);
    // 6: reset while in TX with tx_req held, then a fresh keying sequence
    add(1,1,1,0,0,0,6); add(8,0,1,0,0,1,6); add(2,0,1,0,0,2,6);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++)
        step(vecs[i].rst, vecs[i].req, vecs[i].inh, vecs[i].sel, vecs[i].st, vecs[i].tag);
    end

    // 9: re-key on the release terminal count, then inhibit aborting that keying
    step(1,0,0,0,0,9);
    step(0,1,0,0,1,9); step(0,1,0,0,1,9);
    for (int k = 0; k < 8; k++) step(0,0,0,0,5,9);
    step(0,1,0,0,1,9);
    for (int k = 0; k < 8; k++) step(0,1,1,0,5,9);
    step(0,1,1,0,0,9); step(0,1,1,0,0,9);
    step(0,0,0,0,0,9);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries want 0", sbq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
